// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared control-bundle types, field indices and bubble values for the
// ID/EX, EX/MEM and MEM/WB control pipeline registers.
package ctrl_pipe_pkg;

    typedef logic [1:0] wb_ctrl_t;
    typedef logic [3:0] m_ctrl_t;
    typedef logic [6:0] ex_ctrl_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BNE       = 3;
    localparam int M_BEQ       = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 6;
    localparam int EX_ALUSRC   = 5;

    localparam logic [4:0] ALUOP_NOP = 5'b11111;
    localparam int         CNT_W     = 16;

    localparam wb_ctrl_t WB_BUBBLE = 2'b00;
    localparam m_ctrl_t  M_BUBBLE  = 4'b0000;
    localparam ex_ctrl_t EX_BUBBLE = {1'b0, 1'b0, ALUOP_NOP};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ctrl_pipe_regs_stage_reg.sv
// Width-parameterized pipeline stage register; rst or kill loads the
// bubble value synchronously.
module ctrl_stage_reg #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage register with synchronous bubble insertion.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Control pipeline registers ID/EX -> EX/MEM -> MEM/WB with branch resolution
// in MEM. Optional performance counters enabled by macro CTRL_PIPE_PERF_EN.
module ctrl_pipe_regs
    import ctrl_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [1:0] id_wb,
    input  logic [3:0] id_m,
    input  logic [6:0] id_ex,
    input  logic       stall,
    input  logic       alu_zero,
    output logic       ex_reg_dst,
    output logic       ex_alu_src,
    output logic [4:0] ex_alu_op,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       branch_taken,
    output logic       wb_reg_write,
    output logic       wb_mem_to_reg
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    localparam int IDEX_W  = 13;
    localparam int EXMEM_W = 7;

    logic [IDEX_W-1:0]  idex_d_s;
    logic [IDEX_W-1:0]  idex_q_r;
    logic               idex_kill_s;
    logic [EXMEM_W-1:0] exmem_d_s;
    logic [EXMEM_W-1:0] exmem_q_r;
    logic [1:0]         memwb_q_r;

    wb_ctrl_t idex_wb_s;
    m_ctrl_t  idex_m_s;
    ex_ctrl_t idex_ex_s;
    wb_ctrl_t exmem_wb_s;
    m_ctrl_t  exmem_m_s;
    logic     zero_q_s;
    logic     taken_s;

    assign idex_d_s    = {id_wb, id_m, id_ex};
    assign idex_kill_s = taken_s | stall | ~id_valid;
    assign idex_wb_s   = idex_q_r[12:11];
    assign idex_m_s    = idex_q_r[10:7];
    assign idex_ex_s   = idex_q_r[6:0];

    // The EX field stops here; only WB/M and the zero flag travel on.
    assign exmem_d_s  = {idex_wb_s, idex_m_s, alu_zero};
    assign exmem_wb_s = exmem_q_r[6:5];
    assign exmem_m_s  = exmem_q_r[4:1];
    assign zero_q_s   = exmem_q_r[0];

    assign taken_s = (exmem_m_s[M_BEQ] & zero_q_s) | (exmem_m_s[M_BNE] & ~zero_q_s);

    ctrl_stage_reg #(
        .W      (IDEX_W),
        .BUBBLE ({WB_BUBBLE, M_BUBBLE, EX_BUBBLE})
    ) u_idex (
        .clk  (clk),
        .rst  (rst),
        .kill (idex_kill_s),
        .d    (idex_d_s),
        .q    (idex_q_r)
    );

    ctrl_stage_reg #(
        .W      (EXMEM_W),
        .BUBBLE ({WB_BUBBLE, M_BUBBLE, 1'b0})
    ) u_exmem (
        .clk  (clk),
        .rst  (rst),
        .kill (taken_s),
        .d    (exmem_d_s),
        .q    (exmem_q_r)
    );

    // MEM/WB is never flushed so older instructions still retire.
    ctrl_stage_reg #(
        .W      (2),
        .BUBBLE (WB_BUBBLE)
    ) u_memwb (
        .clk  (clk),
        .rst  (rst),
        .kill (1'b0),
        .d    (exmem_wb_s),
        .q    (memwb_q_r)
    );

    assign ex_reg_dst    = idex_ex_s[EX_REGDST];
    assign ex_alu_src    = idex_ex_s[EX_ALUSRC];
    assign ex_alu_op     = idex_ex_s[4:0];
    assign mem_mem_read  = exmem_m_s[M_MEMREAD];
    assign mem_mem_write = exmem_m_s[M_MEMWRITE];
    assign branch_taken  = taken_s;
    assign wb_reg_write  = memwb_q_r[WB_REGWRITE];
    assign wb_mem_to_reg = memwb_q_r[WB_MEMTOREG];

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    // Saturating counters of hazard bubbles and taken branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (stall || taken_s) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (taken_s) begin
                taken_cnt_r <= sat_inc(taken_cnt_r);
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign taken_cnt  = taken_cnt_r;
`else
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Scoreboard bench for ctrl_pipe_regs: instruction-lifecycle reference model,
// directed scenarios followed by randomized traffic.
module tb_ctrl_pipe_regs;
    import ctrl_pipe_pkg::*;

    localparam int NCYC = 512;

    bit         clk = 1'b0;
    logic       rst, id_valid, stall, alu_zero;
    logic [1:0] id_wb;
    logic [3:0] id_m;
    logic [6:0] id_ex;
    logic       ex_reg_dst, ex_alu_src, mem_mem_read, mem_mem_write;
    logic       branch_taken, wb_reg_write, wb_mem_to_reg;
    logic [4:0] ex_alu_op;
    logic [15:0] bubble_cnt_w, taken_cnt_w;

    ctrl_pipe_regs dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_wb         (id_wb),
        .id_m          (id_m),
        .id_ex         (id_ex),
        .stall         (stall),
        .alu_zero      (alu_zero),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .branch_taken  (branch_taken),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .bubble_cnt    (bubble_cnt_w),
        .taken_cnt     (taken_cnt_w)
`endif
    );

`ifndef CTRL_PIPE_PERF_EN
    assign bubble_cnt_w = 16'd0;
    assign taken_cnt_w  = 16'd0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] outs;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Per-issue-cycle history of the instruction presented in ID.
    bit         z_a  [NCYC];
    bit         tk   [NCYC];
    bit         aid  [NCYC];
    bit         amem [NCYC];
    bit         awb  [NCYC];
    logic [1:0] wb_a [NCYC];
    logic [3:0] m_a  [NCYC];
    logic [6:0] ex_a [NCYC];
    int         cyc = 0;
    int         exp_bub = 0;
    int         exp_tk  = 0;

    localparam logic [1:0] ADD_WB = 2'b10;
    localparam logic [6:0] ADD_EX = 7'b1000001;
    localparam logic [1:0] LD_WB  = 2'b11;
    localparam logic [3:0] LD_M   = 4'b0010;
    localparam logic [6:0] LD_EX  = 7'b0100000;
    localparam logic [6:0] BR_EX  = 7'b0000010;

    function automatic bit aid_at(input int s);
        return (s >= 0) ? aid[s] : 1'b0;
    endfunction
    function automatic bit amem_at(input int s);
        return (s >= 0) ? amem[s] : 1'b0;
    endfunction
    function automatic bit awb_at(input int s);
        return (s >= 0) ? awb[s] : 1'b0;
    endfunction

    // One cycle: predict the outputs visible now, then present new inputs.
    task automatic step(input bit r, input bit v, input bit s, input bit z,
                        input logic [1:0] w, input logic [3:0] m, input logic [6:0] e);
        exp_t       x;
        int         c;
        logic [6:0] ex_e;
        logic [1:0] mm_e;
        logic [1:0] wb_e;
        c = cyc;
        tk[c] = 1'b0;
        if (c >= 2 && amem_at(c - 2)) begin
            tk[c] = (m_a[c-2][2] && z_a[c-1]) || (m_a[c-2][3] && !z_a[c-1]);
        end
        ex_e = aid_at(c - 1) ? ex_a[c-1] : 7'b0011111;
        mm_e = amem_at(c - 2) ? m_a[c-2][1:0] : 2'b00;
        wb_e = awb_at(c - 3) ? wb_a[c-3] : 2'b00;
        if (c >= 1) begin
            x.cyc  = c;
            x.outs = {ex_e, mm_e, tk[c], wb_e};
            x.bc   = exp_bub[15:0];
            x.tc   = exp_tk[15:0];
            exp_q.push_back(x);
        end
        z_a[c] = z; wb_a[c] = w; m_a[c] = m; ex_a[c] = e;
        rst = r; id_valid = v; stall = s; alu_zero = z;
        id_wb = w; id_m = m; id_ex = e;
        aid[c] = v && !s && !tk[c] && !r;
        if (c >= 1) amem[c-1] = aid_at(c - 1) && !tk[c] && !r;
        if (c >= 2) awb[c-2] = amem_at(c - 2) && !r;
        if (r) begin
            exp_bub = 0;
            exp_tk  = 0;
        end else begin
            if ((s || tk[c]) && exp_bub < 65535) exp_bub++;
            if (tk[c] && exp_tk < 65535) exp_tk++;
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 7'b0000000);
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare to the model.
    always @(negedge clk) begin
        exp_t       x;
        logic [11:0] act;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            act = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write,
                   branch_taken, wb_reg_write, wb_mem_to_reg};
            checks++;
            if (act !== x.outs) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %b expected %b", x.cyc, act, x.outs);
            end
`ifdef CTRL_PIPE_PERF_EN
            checks++;
            if (bubble_cnt_w !== x.bc || taken_cnt_w !== x.tc) begin
                errors++;
                $display("FAIL counters cycle %0d: got bubble=%0d taken=%0d expected bubble=%0d taken=%0d",
                         x.cyc, bubble_cnt_w, taken_cnt_w, x.bc, x.tc);
            end
`endif
        end
    end

    initial begin
        logic [1:0] br;
        logic [3:0] rm;
        #2;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 7'b0000000);
        idle(4);
        // ADD retires after three cycles
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // load followed by a one-cycle load-use stall
        step(1'b0, 1'b1, 1'b0, 1'b0, LD_WB, LD_M, LD_EX);
        step(1'b0, 1'b1, 1'b1, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // taken BEQ squashes two younger ADDs
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, BR_EX);
        step(1'b0, 1'b1, 1'b0, 1'b1, ADD_WB, 4'b0000, ADD_EX);
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // not-taken BNE lets ADDs retire
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1000, BR_EX);
        step(1'b0, 1'b1, 1'b0, 1'b1, ADD_WB, 4'b0000, ADD_EX);
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // stall coinciding with a taken branch
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, BR_EX);
        step(1'b0, 1'b1, 1'b0, 1'b1, ADD_WB, 4'b0000, ADD_EX);
        step(1'b0, 1'b1, 1'b1, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // reset while a load sits in MEM
        step(1'b0, 1'b1, 1'b0, 1'b0, LD_WB, LD_M, LD_EX);
        step(1'b0, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        step(1'b1, 1'b1, 1'b0, 1'b0, ADD_WB, 4'b0000, ADD_EX);
        idle(4);
        // randomized traffic; BEQ and BNE are never set together
        for (int i = 0; i < 300; i++) begin
            br = 2'($urandom_range(0, 3));
            rm[1:0] = 2'($urandom);
            rm[3:2] = (br == 2'd2) ? 2'b01 : ((br == 2'd3) ? 2'b10 : 2'b00);
            step(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
                 1'($urandom), 2'($urandom), rm, 7'($urandom));
        end
        idle(4);
        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
